// File: rtl/if_pkg.sv
// if_pkg: shared state type and constants for the instruction prefetch unit.
//   state_t       BOOT / RUN / HOLD fetch states
//   INST_NOP      value presented on finst when nothing is valid
//   PC_STEP       fetch address increment per accepted request
//   RESET_VEC_DEF default first fetch address after reset
package if_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  localparam int INST_NOP = 0;
  localparam int PC_STEP = 2;
  localparam int RESET_VEC_DEF = 0;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: power-of-two deep FIFO with synchronous clear.
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous flush (same effect as rst)
//   push, wdata   write; ignored when full
//   pop, rdata    read of head entry; ignored when empty
//   empty, full   occupancy flags
//   count         number of stored entries (0..DEPTH)
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk)
    if (rst | clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch unit with a prefetch queue feeding decode.
//   clk, rst                      clock, synchronous active-high reset
//   imem_req, imem_addr           fetch request and address (fetch PC)
//   imem_ack, imem_rdata          request accepted, fetched instruction
//   pc_rel_sel, br_pc,
//   pc_rel_offset                 taken-branch redirect to br_pc + offset
//   fvalid, finst, if_pc          head instruction and its PC to decode
//   dec_ready                     decode consumes the head this cycle
// Optional: define IF_PREFETCH_BYPASS_EN to forward an acknowledged fetch
// straight to decode when the queue is empty.
module if_prefetch import if_pkg::*; #(
  parameter int AW = 32,
  parameter int IW = 16,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          pc_rel_sel,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] pc_rel_offset,
  output logic          fvalid,
  output logic [IW-1:0] finst,
  output logic [AW-1:0] if_pc,
  input  logic          dec_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state;
  logic [AW-1:0] fpc;
  logic acc, byp, push, pop, empty, full, going_full;
  logic [CW-1:0] count;
  logic [AW+IW-1:0] head;
  assign imem_req = state == RUN;
  assign imem_addr = fpc;
  assign acc = imem_req & imem_ack;
`ifdef IF_PREFETCH_BYPASS_EN
  // An accepted fetch into an empty queue is shown to decode at once and
  // only stored if decode does not take it this cycle.
  assign byp = empty & acc & !pc_rel_sel;
  assign push = acc & !pc_rel_sel & !(byp & dec_ready);
`else
  assign byp = 1'b0;
  assign push = acc & !pc_rel_sel;
`endif
  assign fvalid = (!empty | byp) & !pc_rel_sel;
  assign pop = fvalid & !empty & dec_ready;
  assign finst = !fvalid ? IW'(INST_NOP) : byp ? imem_rdata : head[IW-1:0];
  assign if_pc = !fvalid ? '0 : byp ? fpc : head[AW+IW-1:IW];
  // The push about to fill the last free slot stops requesting next cycle.
  assign going_full = push & !pop & (count == CW'(DEPTH - 1));
  always_ff @(posedge clk)
    if (rst) begin
      state <= BOOT;
      fpc <= RESET_VEC;
    end else if (pc_rel_sel) begin
      state <= RUN;
      fpc <= br_pc + pc_rel_offset;
    end else begin
      if (acc) fpc <= fpc + AW'(PC_STEP);
      state <= state == BOOT ? RUN :
               state == HOLD ? (full & !pop ? HOLD : RUN) :
               (going_full ? HOLD : RUN);
    end
  if_fifo #(.DEPTH(DEPTH), .W(AW + IW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (pc_rel_sel),
    .push  (push),
    .pop   (pop),
    .wdata ({fpc, imem_rdata}),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed and randomized checks of if_prefetch against a queue-based reference model.
module tb_if_prefetch;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RV = 32'h100;
  logic clk = 1'b0;
  logic rst, imem_req, imem_ack, pc_rel_sel, fvalid, dec_ready;
  logic [AW-1:0] imem_addr, br_pc, pc_rel_offset, if_pc;
  logic [IW-1:0] imem_rdata, finst;
  int checks = 0;
  int errors = 0;
  logic [AW+IW-1:0] q[$];
  logic [AW-1:0] m_fpc;
  bit m_boot, m_init;
  always #5 clk = ~clk;
  if_prefetch #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_rel_sel    (pc_rel_sel),
    .br_pc         (br_pc),
    .pc_rel_offset (pc_rel_offset),
    .fvalid        (fvalid),
    .finst         (finst),
    .if_pc         (if_pc),
    .dec_ready     (dec_ready)
  );
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // One cycle: drive inputs after the falling edge, compare outputs with the
  // model, then advance the model to what the next rising edge should produce.
  task automatic step(input logic r, input logic a, input logic [IW-1:0] d, input logic s,
                      input logic [AW-1:0] b, input logic [AW-1:0] o, input logic rdy);
    logic m_req, byp, fv;
    logic [AW+IW-1:0] hd;
    @(negedge clk);
    rst = r;
    imem_ack = a;
    imem_rdata = d;
    pc_rel_sel = s;
    br_pc = b;
    pc_rel_offset = o;
    dec_ready = rdy;
    #1;
    m_req = !m_boot && q.size() < DEPTH;
    byp = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
    byp = q.size() == 0 && m_req && a && !s;
`endif
    fv = (q.size() > 0 || byp) && !s;
    hd = byp ? {m_fpc, d} : (q.size() > 0 ? q[0] : '0);
    if (m_init) begin
      chk("req", 48'(imem_req), 48'(m_req));
      chk("addr", 48'(imem_addr), 48'(m_fpc));
      chk("fvalid", 48'(fvalid), 48'(fv));
      chk("finst", 48'(finst), fv ? 48'(hd[IW-1:0]) : 48'd0);
      chk("if_pc", 48'(if_pc), fv ? 48'(hd[AW+IW-1:IW]) : 48'd0);
    end
    if (r) begin
      q.delete();
      m_fpc = RV;
      m_boot = 1;
      m_init = 1;
    end else if (s) begin
      q.delete();
      m_fpc = b + o;
      m_boot = 0;
    end else begin
      if (q.size() > 0 && fv && rdy) void'(q.pop_front());
      if (m_req && a && !(byp && rdy)) q.push_back({m_fpc, d});
      if (m_req && a) m_fpc = m_fpc + 2;
      m_boot = 0;
    end
  endtask
  initial begin
    logic [AW-1:0] o;
    logic rdy;
    m_init = 0;
    m_boot = 1;
    m_fpc = RV;
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 16'h1234, 0, 0, 0, 1);
    step(0, 1, 16'hA000, 0, 0, 0, 1);
    chk("boot_req", 48'(imem_req), 48'd0);
    chk("boot_addr", 48'(imem_addr), 48'h100);
    step(0, 1, 16'hA001, 0, 0, 0, 1);
    chk("seq_addr0", 48'(imem_addr), 48'h100);
    step(0, 1, 16'hA002, 0, 0, 0, 1);
    chk("seq_addr1", 48'(imem_addr), 48'h102);
    chk("seq_pc0", 48'(if_pc), 48'h100);
    step(0, 1, 16'hA003, 0, 0, 0, 1);
    chk("seq_addr2", 48'(imem_addr), 48'h104);
    chk("seq_pc1", 48'(if_pc), 48'h102);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 16'hB000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'hB001 + 16'(i), 0, 0, 0, 0);
    step(0, 1, 16'hB100, 0, 0, 0, 0);
    chk("hold_req", 48'(imem_req), 48'd0);
    chk("hold_pc", 48'(if_pc), 48'h100);
    step(0, 1, 16'hB101, 0, 0, 0, 1);
    step(0, 0, 16'hB102, 0, 0, 0, 0);
    chk("resume_req", 48'(imem_req), 48'd1);
    chk("order_pc", 48'(if_pc), 48'h102);
    step(0, 0, 0, 1, 32'hFFFFFFFE, 32'd4, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", 48'(imem_addr), 48'h2);
    step(0, 0, 0, 1, 32'h200, 32'd0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'hC000 + 16'(i), 0, 0, 0, 0);
    step(0, 1, 16'hC0FF, 1, 32'h202, 32'hFFFFFFF0, 1);
    chk("redir_fvalid", 48'(fvalid), 48'd0);
    chk("redir_finst", 48'(finst), 48'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("redir_addr", 48'(imem_addr), 48'h1F2);
    chk("redir_empty", 48'(fvalid), 48'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'hD000 + 16'(i), 0, 0, 0, 0);
    step(1, 1, 16'hD0FF, 0, 0, 0, 0);
    step(0, 1, 16'hD100, 0, 0, 0, 0);
    chk("rst_fvalid", 48'(fvalid), 48'd0);
    chk("rst_req", 48'(imem_req), 48'd0);
    chk("rst_addr", 48'(imem_addr), 48'h100);
    for (int i = 0; i < 800; i++) begin
      o = $urandom_range(0, 1) == 1 ? 32'($urandom) : 32'($urandom_range(0, 64)) - 32'd32;
      rdy = ((i / 50) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
           $urandom_range(0, 15) == 0, 32'($urandom), o, rdy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter AW, 32, fetch address width.
REQ-002 Parameter IW, 16, instruction width.
REQ-003 Parameter DEPTH, 4, prefetch queue entries; power of two, >= 2.
REQ-004 Parameter RESET_VEC, 0, first fetch address after reset.
REQ-005 One clock, CLK; reset RST, synchronous, active-high.
REQ-006 CLK  in  1  clock; all state updates on rising edge.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 IMEM_REQ  out  1  fetch request.
REQ-009 IMEM_ADDR  out  AW  fetch address.
REQ-010 IMEM_ACK  in  1  request accepted; IMEM_RDATA valid this cycle.
REQ-011 IMEM_RDATA  in  IW  fetched instruction.
REQ-012 PC_REL_SEL  in  1  taken branch redirect.
REQ-013 BR_PC  in  AW  PC of branch instruction.
REQ-014 PC_REL_OFFSET  in  AW  signed branch offset.
REQ-015 FVALID  out  1  FINST/IF_PC valid to decode.
REQ-016 FINST  out  IW  head instruction; 0 when FVALID=0.
REQ-017 IF_PC  out  AW  PC of FINST; 0 when FVALID=0.
REQ-018 DEC_READY  in  1  decode accepts head this cycle.

Function
REQ-019 Fetch PC register FPC drives IMEM_ADDR; FPC advances by 2 on each accepted request (IMEM_REQ & IMEM_ACK), modulo 2^AW.
REQ-020 States: BOOT (one cycle after reset, IMEM_REQ=0), RUN (IMEM_REQ=1), HOLD (queue full, IMEM_REQ=0); BOOT->RUN unconditionally; RUN->HOLD when a push makes count=DEPTH; HOLD->RUN when count<DEPTH or on redirect.
REQ-021 Accepted request pushes {FPC, IMEM_RDATA} into queue; no push when count=DEPTH.
REQ-022 FVALID=1 iff queue non-empty and PC_REL_SEL=0; pop occurs when FVALID & DEC_READY.
REQ-023 Simultaneous push and pop leaves count unchanged; pop on empty and push on full never occur.
REQ-024 Redirect (PC_REL_SEL=1): FPC <= BR_PC + PC_REL_OFFSET (mod 2^AW), queue cleared, same-cycle IMEM_ACK data discarded, no pop, FVALID=0, FINST=0; highest priority over push/pop.
REQ-025 Redirect in consecutive cycles: last one wins; fetch resumes at its target the following cycle.
REQ-026 Latency without bypass: ack at cycle N -> FVALID at N+1 with that instruction.
REQ-027 Instruction order at FINST equals request order; no instruction lost or duplicated except by redirect flush.

Reset
REQ-028 RST=1 at any time: state BOOT, FPC=RESET_VEC, queue empty, IMEM_REQ=0, IMEM_ADDR=RESET_VEC, FVALID=0, FINST=0, IF_PC=0; pending ack discarded.
REQ-029 First request issued the second cycle after RST deasserts.

Configuration
REQ-030 Macro IF_PREFETCH_BYPASS_EN defined: when queue empty, IMEM_ACK=1 and no redirect, FINST/IF_PC/FVALID present IMEM_RDATA/FPC combinationally the same cycle; if DEC_READY=1 the entry is not pushed, else pushed.
REQ-031 Macro undefined: no combinational path from IMEM_* to FVALID/FINST/IF_PC; latency per REQ-026.

Structure
REQ-032 Shared package if_pkg: state typedef (BOOT, RUN, HOLD), INST_NOP=0, PC step constant 2, default RESET_VEC.
REQ-033 Queue is sub-module if_fifo (parametrised DEPTH, width AW+IW, with synchronous clear); PC adders reuse existing ADDER.

Verification
REQ-034 Reset release, RESET_VEC=0x100, ACK always 1, DEC_READY=1 -> IMEM_ADDR 0x100,0x102,0x104; IF_PC same sequence one cycle after each ack.
REQ-035 DEC_READY=0, ACK=1, DEPTH=4 -> four pushes then IMEM_REQ=0 (HOLD); raise DEC_READY -> one pop, IMEM_REQ=1 next cycle, order preserved.
REQ-036 Queue holding 0x200..0x204, PC_REL_SEL=1, BR_PC=0x202, offset=-0x10 -> FVALID=0 that cycle, queue empty, next IMEM_ADDR=0x1F2.
REQ-037 BR_PC=0xFFFFFFFE, offset=4 -> next IMEM_ADDR=0x00000002 (wrap).
REQ-038 RST asserted with 3 entries queued and ack active -> next cycle FVALID=0, IMEM_REQ=0, IMEM_ADDR=RESET_VEC.
REQ-039 With IF_PREFETCH_BYPASS_EN, empty queue, ack with RDATA=0xBEEF, DEC_READY=1 -> FVALID=1, FINST=0xBEEF same cycle, queue stays empty; without macro, FINST=0xBEEF next cycle.
